// File: rtl/simple_proc_prog_mem.sv
// Program memory for the simple processor: byte-serial loader into a 2**ADDR_W x DATA_W
// store, then fixed-latency instruction fetch. Words arrive as two bytes, MSB first,
// so DATA_W is expected to be 16. READ_LAT is legal in 1..3.
// Optional trailer-checksum check is compiled in with `define PROG_MEM_CHECKSUM_EN.

module simple_proc_prog_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int READ_LAT = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h3C00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        load_byte,
  input  logic              load_vld,
  output logic              load_ready,
  input  logic              reload,
  output logic              start,
  output logic              load_err,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ram_read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  output logic [2:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_WAIT_LEN = 3'd0,
    S_BYTE_HI  = 3'd1,
    S_BYTE_LO  = 3'd2,
    S_DONE     = 3'd3,
    S_RUN      = 3'd4,
    S_CHECK    = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t            r_state;
  logic              r_load_ready;
  logic              r_start;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_hold;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_vld;

  logic              w_accept;
  logic              w_mem_we;
  logic              w_req;
  logic              w_tap_vld;
  logic [ADDR_W-1:0] w_tap_addr;
  logic [ADDR_W-1:0] w_last_addr;
  logic              w_in_range;

  // Loader handshake: a byte transfers on a rising clk edge where load_vld && load_ready.
  // load_ready is registered and never depends on load_vld; load_vld held high while
  // load_ready is low has no effect, and reload discards a byte offered in its cycle.
  assign w_accept    = load_vld && r_load_ready;
  assign w_last_addr = r_len - ADDR_W'(1);
  assign w_mem_we    = w_accept && !reload && (r_state == S_BYTE_LO);
  assign w_req       = ram_read_en && !reload && (r_state == S_RUN);

`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_load_err;
  assign load_err = r_load_err;
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WAIT_LEN;
      r_load_ready <= 1'b0;
      r_start      <= 1'b0;
      r_len        <= '0;
      r_wr_addr    <= '0;
      r_hold       <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
      r_csum       <= '0;
      r_load_err   <= 1'b0;
`endif
    end else if (reload) begin
      r_state      <= S_WAIT_LEN;
      r_load_ready <= 1'b1;
      r_start      <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      r_load_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_WAIT_LEN: begin
          // load_ready comes up here one cycle after reset
          r_load_ready <= 1'b1;
          if (w_accept) begin
            r_len     <= ADDR_W'(load_byte);
            r_wr_addr <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
            r_csum    <= '0;
`endif
            r_state   <= S_BYTE_HI;
          end
        end
        S_BYTE_HI: begin
          if (w_accept) begin
            r_hold  <= load_byte;
`ifdef PROG_MEM_CHECKSUM_EN
            r_csum  <= r_csum ^ load_byte;
`endif
            r_state <= S_BYTE_LO;
          end
        end
        S_BYTE_LO: begin
          if (w_accept) begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
`ifdef PROG_MEM_CHECKSUM_EN
            r_csum    <= r_csum ^ load_byte;
`endif
            // length 0 wraps to the full depth through the modulo compare
            if (r_wr_addr == w_last_addr) begin
              r_state      <= S_DONE;
              r_load_ready <= 1'b0;
            end else begin
              r_state <= S_BYTE_HI;
            end
          end
        end
        S_DONE: begin
`ifdef PROG_MEM_CHECKSUM_EN
          r_state      <= S_CHECK;
          r_load_ready <= 1'b1;
`else
          r_state      <= S_RUN;
          r_start      <= 1'b1;
`endif
        end
        S_RUN: begin
          r_start <= 1'b1;
        end
`ifdef PROG_MEM_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_load_ready <= 1'b0;
            if (load_byte == r_csum) begin
              r_state <= S_RUN;
              r_start <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_start    <= 1'b0;
          r_load_err <= 1'b1;
        end
`endif
        default: begin
          r_state      <= S_WAIT_LEN;
          r_load_ready <= 1'b0;
          r_start      <= 1'b0;
        end
      endcase
    end
  end

  // Program store: contents survive reset and reload
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_addr] <= {r_hold, load_byte};
    end
  end

  generate
    if (READ_LAT <= 1) begin : g_lat1
      assign w_tap_vld  = w_req;
      assign w_tap_addr = pc;
    end else begin : g_latn
      localparam int STAGES = READ_LAT - 1;
      logic              r_stg_vld  [STAGES];
      logic [ADDR_W-1:0] r_stg_addr [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            r_stg_vld[i]  <= 1'b0;
            r_stg_addr[i] <= '0;
          end
        end else begin
          r_stg_vld[0]  <= w_req;
          r_stg_addr[0] <= pc;
          for (int i = 1; i < STAGES; i++) begin
            r_stg_vld[i]  <= r_stg_vld[i-1];
            r_stg_addr[i] <= r_stg_addr[i-1];
          end
          if (reload) begin
            for (int i = 0; i < STAGES; i++) begin
              r_stg_vld[i] <= 1'b0;
            end
          end
        end
      end

      assign w_tap_vld  = r_stg_vld[STAGES-1];
      assign w_tap_addr = r_stg_addr[STAGES-1];
    end
  endgenerate

  assign w_in_range = (r_len == '0) || (w_tap_addr < r_len);

  // Final stage doubles as the registered memory read; data_out holds between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_vld <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_data_vld <= w_tap_vld && !reload;
      if (w_tap_vld && !reload) begin
        r_data_out <= w_in_range ? r_mem[w_tap_addr] : NOP_WORD;
      end
    end
  end

  assign load_ready = r_load_ready;
  assign start      = r_start;
  assign data_out   = r_data_out;
  assign data_vld   = r_data_vld;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_simple_proc_prog_mem.sv
// Bench for simple_proc_prog_mem: two instances (READ_LAT 1 and 3) share stimulus and are
// compared every cycle against a byte-count level loader model and a fetch scoreboard.

module tb_simple_proc_prog_mem;

  localparam logic [15:0] NOP = 16'h3C00;
`ifdef PROG_MEM_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  localparam int P_LEN   = 0;
  localparam int P_DATA  = 1;
  localparam int P_DONE  = 2;
  localparam int P_RUN   = 3;
  localparam int P_CHECK = 4;
  localparam int P_ERR   = 5;

  logic        clk;
  logic        rst;
  logic [7:0]  load_byte;
  logic        load_vld;
  logic        reload;
  logic [7:0]  pc;
  logic        ram_read_en;

  logic        ready1, start1, err1, dvld1;
  logic [15:0] dout1;
  logic [2:0]  dbg1;
  logic        ready3, start3, err3, dvld3;
  logic [15:0] dout3;
  logic [2:0]  dbg3;

  simple_proc_prog_mem #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_byte(load_byte), .load_vld(load_vld),
    .load_ready(ready1), .reload(reload), .start(start1), .load_err(err1),
    .pc(pc), .ram_read_en(ram_read_en), .data_out(dout1), .data_vld(dvld1),
    .dbg_state(dbg1)
  );

  simple_proc_prog_mem #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .load_byte(load_byte), .load_vld(load_vld),
    .load_ready(ready3), .reload(reload), .start(start3), .load_err(err3),
    .pc(pc), .ram_read_en(ram_read_en), .data_out(dout3), .data_vld(dvld3),
    .dbg_state(dbg3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          phase;
  bit          m_ready;
  int          m_words;
  int          m_nbytes;
  logic [7:0]  m_csum;
  logic [7:0]  m_hi;
  logic [15:0] m_mem [256];
  logic [15:0] m_dout1;
  logic [15:0] m_dout3;
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q3[$];
  int          due_q1[$];
  int          due_q3[$];
  logic [15:0] prog [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void flush_q();
    exp_q1.delete(); due_q1.delete();
    exp_q3.delete(); due_q3.delete();
  endfunction

  function automatic void model_reset();
    phase   = P_LEN;
    m_ready = 1'b0;
    m_words = 0;
    m_dout1 = '0;
    m_dout3 = '0;
    flush_q();
  endfunction

  function automatic void model_step();
    bit acc;
    bit req;
    logic [15:0] word;
    acc = load_vld && m_ready;
    req = ram_read_en && (phase == P_RUN) && !reload;
    if (reload) begin
      flush_q();
      phase = P_LEN;
    end else begin
      if (req) begin
        word = (m_words == 256 || int'(pc) < m_words) ? m_mem[pc] : NOP;
        exp_q1.push_back(word); due_q1.push_back(cyc);
        exp_q3.push_back(word); due_q3.push_back(cyc + 2);
      end
      case (phase)
        P_LEN: if (acc) begin
          m_words  = (load_byte == 8'd0) ? 256 : int'(load_byte);
          m_nbytes = 0;
          m_csum   = '0;
          phase    = P_DATA;
        end
        P_DATA: if (acc) begin
          m_csum = m_csum ^ load_byte;
          if (m_nbytes % 2 == 0) m_hi = load_byte;
          else m_mem[m_nbytes/2] = {m_hi, load_byte};
          m_nbytes++;
          if (m_nbytes == 2 * m_words) phase = P_DONE;
        end
        P_DONE:  phase = CSUM ? P_CHECK : P_RUN;
        P_CHECK: if (acc) phase = (load_byte == m_csum) ? P_RUN : P_ERR;
        default: ;
      endcase
    end
    m_ready = (phase == P_LEN) || (phase == P_DATA) || (phase == P_CHECK);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else model_step();
      #2;
      if (due_q1.size() > 0 && due_q1[0] == cyc) begin
        m_dout1 = exp_q1.pop_front();
        void'(due_q1.pop_front());
        check_eq("dvld1", 32'(dvld1), 32'd1);
      end else begin
        check_eq("dvld1", 32'(dvld1), 32'd0);
      end
      if (due_q3.size() > 0 && due_q3[0] == cyc) begin
        m_dout3 = exp_q3.pop_front();
        void'(due_q3.pop_front());
        check_eq("dvld3", 32'(dvld3), 32'd1);
      end else begin
        check_eq("dvld3", 32'(dvld3), 32'd0);
      end
      check_eq("dout1", 32'(dout1), 32'(m_dout1));
      check_eq("dout3", 32'(dout3), 32'(m_dout3));
      check_eq("ready", 32'({ready1, ready3}), 32'({m_ready, m_ready}));
      check_eq("start", 32'({start1, start3}), 32'({2{phase == P_RUN}}));
      check_eq("err",   32'({err1, err3}),     32'({2{phase == P_ERR}}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      load_vld  = 1'b0;
      load_byte = 8'($urandom);
      tick();
    end
    load_byte = b;
    load_vld  = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = m_ready;
      tick();
    end
    load_vld = 1'b0;
    if (!acc) check_eq("load_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_program(input int nwords, input bit bad_trailer);
    logic [7:0] cs = '0;
    send_byte(nwords == 256 ? 8'h00 : 8'(nwords));
    for (int i = 0; i < nwords; i++) begin
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
      cs = cs ^ prog[i][15:8] ^ prog[i][7:0];
    end
    if (CSUM) send_byte(bad_trailer ? ~cs : cs);
    repeat (2) tick();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic fetch1(input logic [7:0] a);
    ram_read_en = 1'b1;
    pc = a;
    tick();
    ram_read_en = 1'b0;
  endtask

  task automatic run_fetches(input int ncyc, input int maxpc, input bit allow_reload);
    for (int c = 0; c < ncyc; c++) begin
      ram_read_en = 1'($urandom_range(0, 1));
      pc          = 8'($urandom_range(0, maxpc));
      load_vld    = ($urandom_range(0, 3) == 0);
      load_byte   = 8'($urandom);
      reload      = allow_reload && ($urandom_range(0, 59) == 0);
      tick();
    end
    ram_read_en = 1'b0;
    load_vld    = 1'b0;
    reload      = 1'b0;
    repeat (4) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; load_byte = '0; load_vld = 1'b0; reload = 1'b0;
    pc = '0; ram_read_en = 1'b0;
    repeat (3) tick();
    check_eq("rst_outputs", 32'({ready1, start1, err1, dvld1, dout1}), 32'd0);
    rst = 1'b0;
    tick();

    // Directed: three-word program, start timing after the final byte
    prog[0] = 16'h0001; prog[1] = 16'h0402; prog[2] = 16'h3C00;
    send_byte(8'd3);
    for (int i = 0; i < 3; i++) begin
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
    end
`ifndef PROG_MEM_CHECKSUM_EN
    check_eq("t1_start_lo", 32'({start1, ready1}), 32'd0);
    tick();
    check_eq("t1_start_hi", 32'({start1, ready1}), 32'b10);
`else
    send_byte(8'h3B);
`endif
    repeat (2) tick();

    // Single fetch, hold of data_out
    fetch1(8'd1);
    check_eq("t2_dout", 32'(dout1), 32'h0402);
    check_eq("t2_vld", 32'(dvld1), 32'd1);
    repeat (5) tick();
    check_eq("t2_hold", 32'({dvld1, dout1}), 32'h0402);

    // Out-of-range address and back-to-back fetches on the slow instance
    fetch1(8'd5);
    check_eq("t3_nop", 32'(dout1), 32'h3C00);
    repeat (3) tick();
    ram_read_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 8'(i);
      tick();
    end
    ram_read_en = 1'b0;
    check_eq("t3_b2b_0", 32'({dvld3, dout3}), 32'h10001);
    tick();
    check_eq("t3_b2b_1", 32'({dvld3, dout3}), 32'h10402);
    tick();
    check_eq("t3_b2b_2", 32'({dvld3, dout3}), 32'h13C00);
    repeat (2) tick();

    // Reload together with a fetch
    ram_read_en = 1'b1; pc = 8'd2; reload = 1'b1;
    tick();
    ram_read_en = 1'b0; reload = 1'b0;
    check_eq("t4_after_reload", 32'({start1, ready1, dvld1}), 32'b010);
    prog[0] = 16'hABCD;
    load_program(1, 1'b0);
    fetch1(8'd0);
    check_eq("t4_reload_word", 32'(dout1), 32'hABCD);
    repeat (3) tick();

    // Asynchronous reset in the middle of a load
    pulse_reload();
    send_byte(8'd2);
    send_byte(8'hAA);
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("t5_async_rst", 32'({ready1, start1, dvld1, dout1}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    prog[0] = 16'h5A5A;
    load_program(1, 1'b0);
    fetch1(8'd0);
    check_eq("t5_len_after_rst", 32'(dout1), 32'h5A5A);
    repeat (3) tick();

`ifdef PROG_MEM_CHECKSUM_EN
    pulse_reload();
    send_byte(8'd1); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    check_eq("t6_csum_ok", 32'({start1, err1}), 32'b10);
    pulse_reload();
    send_byte(8'd1); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    check_eq("t6_csum_bad", 32'({start1, err1}), 32'b01);
    run_fetches(6, 3, 1'b0);
    check_eq("t6_err_held", 32'({start1, err1}), 32'b01);
    pulse_reload();
    check_eq("t6_err_clear", 32'(err1), 32'd0);
`endif

    // Full-depth program (length byte 0)
    pulse_reload();
    for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
    load_program(256, 1'b0);
    run_fetches(60, 255, 1'b0);

    // Randomized programs, fetches, junk load bytes, reloads and resets
    for (int it = 0; it < 30; it++) begin
      int n;
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
      end else begin
        pulse_reload();
      end
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) prog[i] = 16'($urandom);
      load_program(n, $urandom_range(0, 4) == 0);
      run_fetches(40, n + 4, 1'b1);
    end

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/simple_proc_prog_mem.md
Name: simple_proc_prog_mem

Overview:
Program-memory responder for the simple processor's instruction-fetch interface. It holds a 256 x 16 instruction store and receives the program over a byte-serial load port. Once the load completes it asserts start. It then answers each fetch (pc + ram_read_en) with the instruction word and a data_vld pulse after a fixed latency. It sits between the host/boot loader and simple_proc_data_proc.

Parameters:
ADDR_W, 8, program address width; depth = 2**ADDR_W words.
DATA_W, 16, instruction width; loaded as DATA_W/8 bytes, MSB first.
READ_LAT, 1, cycles from fetch request to data_vld; legal range 1..3.
NOP_WORD, 16'h3C00, word returned for addresses at or beyond the loaded length (cc=00, opcode=1111).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
load_byte  in  8  loader byte.
load_vld  in  1  load_byte valid; accepted when load_vld && load_ready.
load_ready  out  1  loader can accept a byte.
reload  in  1  single-cycle pulse; aborts run and returns to waiting for a new program.
start  out  1  level; high while a program is loaded and running.
load_err  out  1  checksum failure flag (optional feature only; otherwise 0).
pc  in  ADDR_W  fetch address from the processor.
ram_read_en  in  1  fetch request; sampled each cycle.
data_out  out  DATA_W  instruction word; holds its value until the next response.
data_vld  out  1  one-cycle pulse marking a new data_out.

Behaviour:
- Reset (async, rst=1) values:
  - start=0, load_ready=0, data_vld=0, data_out=0, load_err=0.
  - FSM=WAIT_LEN; length=0; read pipeline cleared.
  - Memory contents are not reset.
- FSM states and transitions:
  - WAIT_LEN: load_ready=1. An accepted byte sets length (0 means 2**ADDR_W words) and wr_addr=0. Goes to BYTE_HI.
  - BYTE_HI: load_ready=1. The accepted byte goes into the holding register [15:8]. Goes to BYTE_LO.
  - BYTE_LO: load_ready=1. The accepted byte is combined with the holding register and written to mem[wr_addr], then wr_addr increments.
    - If wr_addr == length-1 (modulo 2**ADDR_W), go to DONE.
    - Otherwise go to BYTE_HI.
  - DONE: one cycle, load_ready=0. Goes to RUN (or to CHECK when the optional feature is compiled in).
  - RUN: start=1, load_ready=0. Fetches are served.
- reload=1 in any state:
  - Next state is WAIT_LEN; start drops the following cycle.
  - The in-flight read pipeline is flushed, so no data_vld follows.
  - reload takes priority over a simultaneous load byte or fetch.
- Extra bytes offered while load_ready=0 are not accepted (load_vld ignored).
- Fetch path:
  - Only in RUN: ram_read_en=1 captures pc into stage 0.
  - After READ_LAT cycles: data_vld=1 for one cycle, data_out = mem[pc] if pc < length, else NOP_WORD. For length=0, every address is valid.
  - ram_read_en outside RUN is ignored.
  - Back-to-back requests on consecutive cycles are each answered in order; the pipeline is fully pipelined.
- data_out is never cleared after reset; it retains the last served word. The processor samples it combinationally in later states.
- Writes and reads never overlap, since reads occur only in RUN. Memory is one synchronous-write, registered-read array.

Optional Feature:
PROG_MEM_CHECKSUM_EN
- Defined:
  - After the last data byte, the FSM enters CHECK with load_ready=1 and accepts one more byte.
  - That byte must equal the XOR of all data bytes.
  - Match: go to RUN.
  - Mismatch: go to ERR. In ERR, load_err=1, start=0, fetches are ignored, and the block stays there until reload, which clears load_err.
- Undefined:
  - DONE goes directly to RUN; no trailer byte is expected.
  - load_err is tied to 0.

Test Plan:
1. Reset then load len=3, words 0x0001/0x0402/0x3C00 (bytes 03,00,01,04,02,3C,00) -> start rises exactly 2 cycles after the final byte is accepted; load_ready=0 afterwards.
2. In RUN, ram_read_en=1 with pc=1, READ_LAT=1 -> data_vld one cycle later, data_out=0x0402. data_out still reads 0x0402 five cycles later, with data_vld=0.
3. pc=5 with length=3 -> data_out=0x3C00. Fetches on pc=0,1,2 on back-to-back cycles with READ_LAT=3 -> three data_vld pulses, in order, starting 3 cycles later.
4. reload asserted in the same cycle as ram_read_en -> no data_vld; start=0 next cycle; load_ready=1; new load of len=1 word 0xABCD, then fetch pc=0 -> 0xABCD.
5. rst pulsed mid-load (after the BYTE_HI byte) -> outputs return to reset values immediately; the next accepted byte is treated as a length.
6. With PROG_MEM_CHECKSUM_EN: len=1, word 0x1234, trailer 0x26 -> start=1. Same load with trailer 0x00 -> load_err=1 and start=0, held until reload.
